// File: rtl/word_mem_initiator.sv
// word_mem_initiator
//   Turns 16-bit word read/write requests from the control sequencer into two
//   little-endian byte transactions on the byte-wide synchronous main memory
//   port (registered read data: mem_rdata reflects mem_addr from the previous
//   edge). Completion is a one-cycle rsp_valid pulse.
//
//   Optional feature macro: ADDR_CHECK_EN
//     defined   - requests touching bytes at or above MEM_DEPTH issue no memory
//                 cycle and complete at once with rsp_err=1 (rsp_rdata=0 on reads).
//     undefined - rsp_err is tied 0; addresses go to memory unchanged.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = block idle)
//   req_write             1 = write word, 0 = read word
//   req_addr, req_wdata   byte address of low byte, write word
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read word / address error, valid with rsp_valid
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata     byte-wide main memory port
module word_mem_initiator #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  // The memory port is 16 bits wide; deeper memories cannot be addressed.
  if (MEM_DEPTH < 2 || MEM_DEPTH > 65536) begin : g_bad_depth
    $error("word_mem_initiator: MEM_DEPTH out of range");
  end

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_WAIT, RD_HI, WR_LO, WR_HI
  } state_t;

  state_t      state, state_d;
  logic [15:0] addr_q, addr_d;        // latched word address
  logic [7:0]  hi_q, hi_d;            // latched high write byte
  logic [7:0]  lo_q, lo_d;            // low read byte, captured in RD_WAIT
  logic [15:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic        mem_we_d;
  logic        rsp_valid_d;
  logic [15:0] rsp_rdata_d;

  assign req_ready = (state == IDLE);

`ifdef ADDR_CHECK_EN
  logic        rsp_err_q, rsp_err_d;
  logic        req_oob;
  logic [15:0] req_addr_p1;

  // A+1 wraps modulo 2^16, so 0xFFFF is caught by its own low-byte test.
  assign req_addr_p1 = req_addr + 16'd1;
  assign req_oob     = (32'(req_addr) >= MEM_DEPTH) || (32'(req_addr_p1) >= MEM_DEPTH);
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a hold/default value before the
    // case so no path leaves one unassigned (which would infer a latch).
    state_d     = state;
    addr_d      = addr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = mem_we;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
`ifdef ADDR_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          hi_d   = req_wdata[15:8];
`ifdef ADDR_CHECK_EN
          if (req_oob) begin
            // No memory cycle; complete immediately and stay idle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            if (!req_write) rsp_rdata_d = '0;
          end else
`endif
          if (req_write) begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata[7:0];
            mem_we_d    = 1'b1;
            state_d     = WR_LO;
          end else begin
            mem_addr_d  = req_addr;
            mem_we_d    = 1'b0;
            state_d     = RD_LO;
          end
        end
      end
      RD_LO: begin
        mem_addr_d = addr_q + 16'd1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        // Memory has now registered mem[A].
        lo_d    = mem_rdata;
        state_d = RD_HI;
      end
      RD_HI: begin
        rsp_rdata_d = {mem_rdata, lo_q};
        rsp_valid_d = 1'b1;
`ifdef ADDR_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = IDLE;
      end
      WR_LO: begin
        mem_addr_d  = addr_q + 16'd1;
        mem_wdata_d = hi_q;
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
`ifdef ADDR_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef ADDR_CHECK_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
`ifdef ADDR_CHECK_EN
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

endmodule

// File: doc/word_mem_initiator.md
# word_mem_initiator

Memory-side initiator for the accumulator CPU: accepts 16-bit word read/write requests from the control sequencer and drives the byte-wide synchronous main memory port (16Ki x 8, registered read data) as two little-endian byte transactions. It sits between the control unit and main memory, replacing direct MAR/MBR-to-memory wiring. Completion is signalled with a single-cycle response pulse.

## Interface
- MEM_DEPTH, 16384: number of byte locations in main memory; used only by the address check.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept; equals (state == IDLE).
- req_write  in  1  1 = write word, 0 = read word.
- req_addr  in  16  byte address of low byte; any alignment is legal.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read word; valid while rsp_valid is high after a read.
- rsp_err  out  1  address out of range; valid while rsp_valid is high.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  8  memory write byte.
- mem_we  out  1  memory write enable.
- mem_rdata  in  8  memory read byte, registered in memory: it reflects the mem_addr sampled at the previous edge.

## Operation
- All outputs are registered except req_ready.
- Reset values: mem_addr 0, mem_wdata 0, mem_we 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; state IDLE.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Address and data are latched at accept; later changes are ignored.
- States: IDLE, RD_LO, RD_WAIT, RD_HI, WR_LO, WR_HI.
- Read of address A:
  - At accept: mem_addr <= A, mem_we <= 0; go to RD_LO.
  - In RD_LO: mem_addr <= A+1; go to RD_WAIT.
  - In RD_WAIT: latch low byte from mem_rdata (mem[A]); go to RD_HI.
  - In RD_HI: rsp_rdata <= {mem_rdata, low}; rsp_valid <= 1; go to IDLE.
- Write of address A:
  - At accept: mem_addr <= A, mem_wdata <= wdata[7:0], mem_we <= 1; go to WR_LO.
  - In WR_LO: mem_addr <= A+1, mem_wdata <= wdata[15:8]; go to WR_HI.
  - In WR_HI: mem_we <= 0; rsp_valid <= 1; go to IDLE.
- A+1 is computed modulo 2^16, so 0xFFFF wraps to 0x0000.
- rsp_rdata holds its last value until the next read completes. Writes leave rsp_rdata unchanged.
- rsp_valid is high for exactly one cycle per request. Outputs are never in flight across two requests.

## Timing
- Read latency: rsp_valid is high in the cycle after the 4th rising edge counted from the accept edge, i.e. accept edge + 3 further edges.
- Write latency: rsp_valid is high after accept edge + 2 further edges.
- The memory writes the low byte at accept+1 and the high byte at accept+2.
- Back-to-back: req_ready is high in the same cycle as rsp_valid, so a new request can be accepted at the end of that cycle. Sustained throughput is one read per 4 cycles and one write per 3 cycles.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), mem_we drops, and the pending response is lost. A write interrupted after the low byte leaves a partially written word; this is accepted behaviour.

## Configuration
- ADDR_CHECK_EN:
  - Defined: a request with A ≥ MEM_DEPTH or A+1 ≥ MEM_DEPTH (wrap included) is accepted but issues no memory cycle. mem_we stays 0 and mem_addr is unchanged. rsp_valid pulses one edge after accept with rsp_err=1; for reads, rsp_rdata=0.
  - Undefined: rsp_err is tied 0, every address is forwarded unchanged, and the memory truncates it.

## Test plan
- Write 0xBEEF to 0x0010: mem[0x10]=0xEF and mem[0x11]=0xBE, with rsp_valid 2 edges after accept. Then read 0x0010: rsp_rdata=0xBEEF, rsp_valid 3 edges after accept, rsp_err=0.
- Unaligned read of 0x0011 with mem[0x11]=0xBE and mem[0x12]=0x34 -> rsp_rdata=0x34BE.
- req_valid held high for two reads (0x0000, 0x0002): the second is accepted in the same cycle as the first rsp_valid. The two rsp_valid pulses are 4 cycles apart.
- ADDR_CHECK_EN defined: read 0x3FFF -> rsp_err=1, rsp_rdata=0 one edge after accept, mem_addr unchanged. Write 0x4000 -> mem_we never asserted, rsp_err=1. Macro undefined: read 0xFFFF -> mem_addr sequence 0xFFFF, 0x0000.
- Reset asserted during WR_HI -> mem_we=0 immediately and no rsp_valid. After release, req_ready=1 and mem[A] holds the low byte only.
